// File: rtl/fir_tap_sequencer_if.sv
// rtl/fir_tap_sequencer_if.sv - stream handshake bundle used by the FIR tap sequencer
interface fir_tap_sequencer_if #(
  parameter int W = 16
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - time-multiplexed FIR controller sharing one MAC across all taps
module fir_tap_sequencer #(
  parameter int NTAPS = 16,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int AW    = $clog2(NTAPS),
  parameter int OW    = DW + CW + $clog2(NTAPS)
) (
  input  logic                  clock,
  input  logic                  reset,
  fir_tap_sequencer_if.slave    s_axis,
  fir_tap_sequencer_if.master   m_axis,
  input  logic                  coef_we,
  input  logic [AW-1:0]         coef_addr,
  input  logic [CW-1:0]         coef_data,
  output logic                  coef_ready,
  output logic                  idle
);

  localparam logic [1:0] ST_CLR  = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_MAC  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  // Last valid tap index, and the tap count widened so NTAPS = 2**AW still compares correctly.
  localparam logic [AW-1:0] LAST    = AW'(NTAPS - 1);
  localparam logic [AW:0]   NTAPS_W = (AW + 1)'(NTAPS);

  logic [1:0]             state;
  logic [AW-1:0]          cnt;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic signed [OW-1:0]   acc;
  logic signed [DW-1:0]   delay_mem [NTAPS];
  logic signed [CW-1:0]   coef_mem  [NTAPS];
  logic signed [DW+CW-1:0] product;
  logic signed [OW-1:0]   product_ext;

  // All handshake outputs decode from state only; the result is the accumulator itself.
  assign idle          = (state == ST_IDLE);
  assign s_axis.tready = idle;
  assign coef_ready    = idle;
  assign m_axis.tvalid = (state == ST_OUT);
  assign m_axis.tdata  = acc;

  // rd_ptr walks backwards from the newest sample while cnt walks the coefficients forwards.
  assign product     = delay_mem[rd_ptr] * coef_mem[cnt];
  assign product_ext = {{(OW - DW - CW){product[DW+CW-1]}}, product};

  // Sequencing: clear walk, sample accept, NTAPS MAC steps, then hold the result until taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_CLR;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      acc    <= '0;
    end else begin
      case (state)
        ST_CLR: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (s_axis.tvalid) begin
            rd_ptr <= wr_ptr;
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            cnt    <= '0;
            state  <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc    <= ((cnt == '0) ? '0 : acc) + product_ext;
          rd_ptr <= (rd_ptr == '0) ? LAST : rd_ptr - 1'b1;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= ST_OUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_OUT: begin
          if (m_axis.tready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_CLR;
      endcase
    end
  end

  // Storage: CLR zeroes one delay/coefficient pair per cycle; IDLE takes samples and coefficient writes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == ST_CLR) begin
        delay_mem[cnt] <= '0;
        coef_mem[cnt]  <= '0;
      end else if (state == ST_IDLE) begin
        if (s_axis.tvalid) begin
          delay_mem[wr_ptr] <= s_axis.tdata;
        end
        if (coef_we && ({1'b0, coef_addr} < NTAPS_W)) begin
          coef_mem[coef_addr] <= coef_data;
        end
      end
    end
  end

endmodule
